// File: rtl/adc_align_pkg.sv
// adc_align_pkg: shared FSM state type and default parameters for the ADC frame aligner
package adc_align_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;
  localparam int         W_DEF             = 8;
  localparam logic [7:0] FRAME_PATTERN_DEF = 8'hF0;
  localparam int         LOCK_COUNT_DEF    = 16;
  localparam int         LOSS_COUNT_DEF    = 4;
  localparam int         SETTLE_DEF        = 4;
endpackage

// File: rtl/adc_lane_merge.sv
// adc_lane_merge: registered bit interleave of two deserialized data lanes into one sample
// ports: adc_clk/adc_rst_n clock and async active-low reset; lane0_data -> odd sample bits,
//        lane1_data -> even sample bits; sample is the merged word, one cycle after its lanes
module adc_lane_merge #(
  parameter int W = 8
) (
  input  logic           adc_clk,
  input  logic           adc_rst_n,
  input  logic [W-1:0]   lane0_data,
  input  logic [W-1:0]   lane1_data,
  output logic [2*W-1:0] sample
);
  logic [2*W-1:0] w_mix;
  logic [2*W-1:0] r_sample;
  for (genvar k = 0; k < W; k++) begin : g_bit
    assign w_mix[2*k+1] = lane0_data[k];
    assign w_mix[2*k]   = lane1_data[k];
  end
  always_ff @(posedge adc_clk or negedge adc_rst_n)
    if (!adc_rst_n) r_sample <= '0;
    else            r_sample <= w_mix;
  assign sample = r_sample;
endmodule

// File: rtl/adc_frame_align.sv
// adc_frame_align: bitslip-based frame alignment and sample reassembly for one ADC channel
// ports: adc_clk/adc_rst_n clock and async active-low reset; rx_locked serdes lock; retrain
//        restart request; fr_data frame lane; lane0_data/lane1_data data lanes; bitslip pulse
//        to all lanes; sample/sample_valid merged output; locked, align_err, slip_count status
module adc_frame_align
  import adc_align_pkg::*;
#(
  parameter int           W             = W_DEF,
  parameter logic [W-1:0] FRAME_PATTERN = W'(FRAME_PATTERN_DEF),
  parameter int           LOCK_COUNT    = LOCK_COUNT_DEF,
  parameter int           LOSS_COUNT    = LOSS_COUNT_DEF,
  parameter int           SETTLE        = SETTLE_DEF
) (
  input  logic                 adc_clk,
  input  logic                 adc_rst_n,
  input  logic                 rx_locked,
  input  logic                 retrain,
  input  logic [W-1:0]         fr_data,
  input  logic [W-1:0]         lane0_data,
  input  logic [W-1:0]         lane1_data,
  output logic                 bitslip,
  output logic [2*W-1:0]       sample,
  output logic                 sample_valid,
  output logic                 locked,
  output logic                 align_err,
  output logic [$clog2(W)-1:0] slip_count
);
  localparam int SW = $clog2(W);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(W - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_COUNT - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(SETTLE - 1);
  state_t r_state, w_state;
  logic [MW-1:0] r_match, w_match;
  logic [LW-1:0] r_miss, w_miss;
  logic [SW-1:0] r_slip, w_slip;
  logic [TW-1:0] r_wait, w_wait;
  logic r_valid, r_err;
  logic w_hit;
  assign w_hit = fr_data == FRAME_PATTERN;
  always_ff @(posedge adc_clk or negedge adc_rst_n)
    if (!adc_rst_n) begin
      r_state <= ST_IDLE;
      r_match <= '0;
      r_miss  <= '0;
      r_slip  <= '0;
      r_wait  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_match <= w_match;
      r_miss  <= w_miss;
      r_slip  <= w_slip;
      r_wait  <= w_wait;
      r_valid <= r_state == ST_LOCKED && rx_locked;
      r_err   <= retrain ? 1'b0 : (r_err || r_state == ST_FAIL);
    end
  always_comb begin
    w_state = r_state;
    w_match = r_match;
    w_miss  = r_miss;
    w_slip  = r_slip;
    w_wait  = r_wait;
    case (r_state)
      ST_IDLE: begin
        w_match = '0;
        w_miss  = '0;
        w_slip  = '0;
        w_wait  = '0;
        w_state = ST_CHECK;
      end
      ST_CHECK:
        if (w_hit) begin
          w_match = r_match == MATCH_LAST ? '0 : r_match + MW'(1);
          w_miss  = '0;
          w_state = r_match == MATCH_LAST ? ST_LOCKED : ST_CHECK;
        end else begin
          w_match = '0;
          w_state = r_slip < SLIP_MAX ? ST_SLIP : ST_FAIL;
        end
      ST_SLIP: begin
        w_slip  = r_slip == SLIP_MAX ? r_slip : r_slip + SW'(1);
        w_wait  = '0;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_wait  = r_wait == WAIT_LAST ? '0 : r_wait + TW'(1);
        w_state = r_wait == WAIT_LAST ? ST_CHECK : ST_WAIT;
      end
      ST_LOCKED:
        if (w_hit) w_miss = '0;
        else if (r_miss == MISS_LAST) begin
          w_miss  = '0;
          w_match = '0;
          w_slip  = '0;
          w_state = ST_CHECK;
        end else w_miss = r_miss + LW'(1);
      ST_FAIL: begin
        w_slip  = '0;
        w_match = '0;
        w_state = ST_CHECK;
      end
      default: w_state = ST_IDLE;
    endcase
    // loss of serdes lock outranks retrain, and both outrank every FSM transition
    if (!rx_locked || retrain) begin
      w_state = ST_IDLE;
      w_match = '0;
      w_miss  = '0;
      w_slip  = '0;
      w_wait  = '0;
    end
  end
  assign bitslip      = r_state == ST_SLIP && rx_locked;
  assign locked       = r_state == ST_LOCKED && rx_locked;
  assign sample_valid = r_valid && rx_locked;
  assign align_err    = r_err;
  assign slip_count   = r_slip;
  adc_lane_merge #(.W(W)) u_merge (
    .adc_clk   (adc_clk),
    .adc_rst_n (adc_rst_n),
    .lane0_data(lane0_data),
    .lane1_data(lane1_data),
    .sample    (sample)
  );
endmodule

// File: tb/tb_adc_frame_align.sv
// tb_adc_frame_align: self-checking bench for adc_frame_align with a rotating frame-lane model
module tb_adc_frame_align;
  localparam int W = 8;
  typedef struct {
    logic [7:0]  l0;
    logic [7:0]  l1;
    logic [15:0] exp;
  } vec_t;
  logic adc_clk = 0, adc_rst_n = 1, rx_locked = 0, retrain = 0;
  logic [W-1:0] fr_data, fr_force = 0, lane0_data = 0, lane1_data = 0;
  logic fr_mode = 0;
  int rot = 0;
  logic bitslip, sample_valid, locked, align_err;
  logic [2*W-1:0] sample;
  logic [2:0] slip_count;
  logic [15:0] w_pat;
  int n_vec = 0, n_err = 0, lat, ns;
  int p[8];
  vec_t tbl[8];
  logic [15:0] q[$];
  always #5 adc_clk = ~adc_clk;
  always_comb begin
    w_pat   = {8'hF0, 8'hF0} << rot;
    fr_data = fr_mode ? fr_force : w_pat[15:8];
  end
  adc_frame_align dut (
    .adc_clk     (adc_clk),
    .adc_rst_n   (adc_rst_n),
    .rx_locked   (rx_locked),
    .retrain     (retrain),
    .fr_data     (fr_data),
    .lane0_data  (lane0_data),
    .lane1_data  (lane1_data),
    .bitslip     (bitslip),
    .sample      (sample),
    .sample_valid(sample_valid),
    .locked      (locked),
    .align_err   (align_err),
    .slip_count  (slip_count)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    logic s;
    s = bitslip;
    @(posedge adc_clk);
    @(negedge adc_clk);
    if (s && rot > 0) rot--;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'hFF, 8'h00, 16'hAAAA};
    tbl[1] = '{8'h00, 8'hFF, 16'h5555};
    tbl[2] = '{8'hFF, 8'hFF, 16'hFFFF};
    tbl[3] = '{8'hF0, 8'h0F, 16'hAA55};
    tbl[4] = '{8'h01, 8'h80, 16'h4002};
    tbl[5] = '{8'h0F, 8'hF0, 16'h55AA};
    tbl[6] = '{8'h3C, 8'hC3, 16'h5AA5};
    tbl[7] = '{8'h00, 8'h00, 16'h0000};
    #2 adc_rst_n = 0;
    #1;
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", locked, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_err", align_err, 0);
    chk("rst_slip", slip_count, 0);
    chk("rst_sample", sample, 0);
    repeat (2) @(negedge adc_clk);
    adc_rst_n = 1;
    tick();
    tick();
    chk("idle_locked", locked, 0);
    rx_locked = 1;
    lat = 0;
    ns = 0;
    while (!locked && lat < 100) begin
      tick();
      lat++;
      if (bitslip) ns++;
    end
    chk("lock_latency", lat, 17);
    chk("lock_no_slip", ns, 0);
    chk("lock_slip_count", slip_count, 0);
    chk("valid_lag", sample_valid, 0);
    tick();
    chk("valid_on", sample_valid, 1);
    for (int i = 0; i < 8; i++) begin
      lane0_data = tbl[i].l0;
      lane1_data = tbl[i].l1;
      q.push_back(tbl[i].exp);
      tick();
      chk("sample", sample, q.pop_front());
      chk("sample_valid", sample_valid, 1);
    end
    fr_mode  = 1;
    fr_force = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("locked_3miss", locked, 1);
    end
    fr_mode = 0;
    tick();
    chk("locked_rematch", locked, 1);
    fr_mode = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("locked_4miss", locked, (i < 3) ? 1 : 0);
    end
    chk("loss_slip_count", slip_count, 0);
    fr_mode = 0;
    tick();
    chk("loss_valid", sample_valid, 0);
    rx_locked = 0;
    tick();
    tick();
    chk("drop_locked", locked, 0);
    rot = 3;
    rx_locked = 1;
    lat = 0;
    ns = 0;
    while (!locked && lat < 300) begin
      tick();
      lat++;
      if (bitslip) begin
        if (ns < 8) p[ns] = lat;
        ns++;
      end
    end
    chk("rot_slips", ns, 3);
    chk("rot_first", p[0], 2);
    chk("rot_gap1", p[1] - p[0], 6);
    chk("rot_gap2", p[2] - p[1], 6);
    chk("rot_latency", lat, 35);
    chk("rot_slip_count", slip_count, 3);
    rx_locked = 0;
    tick();
    tick();
    fr_mode  = 1;
    fr_force = 8'h00;
    rx_locked = 1;
    lat = 0;
    ns = 0;
    while (!align_err && lat < 300) begin
      tick();
      lat++;
      if (bitslip) ns++;
    end
    chk("fail_slips", ns, 7);
    chk("fail_err", align_err, 1);
    chk("fail_slip_clear", slip_count, 0);
    lat = 0;
    while (!bitslip && lat < 20) begin
      tick();
      lat++;
    end
    chk("retry_slip", bitslip, 1);
    chk("err_sticky", align_err, 1);
    retrain = 1;
    tick();
    retrain = 0;
    chk("retrain_err", align_err, 0);
    chk("retrain_slip", slip_count, 0);
    lat = 0;
    while (!bitslip && lat < 20) begin
      tick();
      lat++;
    end
    chk("wait_pre_slip", bitslip, 1);
    tick();
    rx_locked = 0;
    tick();
    chk("drop_wait_bitslip", bitslip, 0);
    chk("drop_wait_locked", locked, 0);
    chk("drop_wait_valid", sample_valid, 0);
    chk("drop_wait_slip", slip_count, 0);
    rx_locked = 1;
    lat = 0;
    while (!bitslip && lat < 20) begin
      tick();
      lat++;
    end
    chk("rst_pre_slip", bitslip, 1);
    adc_rst_n = 0;
    #1;
    chk("rst_slip_bitslip", bitslip, 0);
    chk("rst_slip_locked", locked, 0);
    chk("rst_slip_valid", sample_valid, 0);
    chk("rst_slip_count", slip_count, 0);
    chk("rst_slip_sample", sample, 0);
    fr_mode = 0;
    rot = 0;
    @(negedge adc_clk);
    @(negedge adc_clk);
    adc_rst_n = 1;
    lat = 0;
    while (!locked && lat < 100) begin
      tick();
      lat++;
    end
    chk("relock_latency", lat, 17);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
